// File: rtl/cpu_pkg.sv
// Shared fetch-stage constants and the fetch request state encoding.
package cpu_pkg;
  localparam int PC_W  = 32;
  localparam int INS_W = 32;
  localparam int AW    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  localparam logic [PC_W-1:0] RESET_PC = '0;
endpackage

// File: rtl/fetch_fifo.sv
// Instruction/PC buffer between fetch and execute: registered storage,
// head read combinationally, synchronous flush overriding push and pop.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rstd,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: PC register, instruction memory request FSM and the
// instruction buffer feeding execute.
//   state | meaning
//   IDLE  | no request outstanding
//   REQ   | request outstanding for fetch_pc
//   DROP  | request outstanding whose data will be discarded
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = cpu_pkg::PC_W,
  parameter int AW    = cpu_pkg::AW,
  parameter int INS_W = cpu_pkg::INS_W,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstd,
  output logic             imem_req,
  output logic [AW-1:0]    imem_addr,
  input  logic             imem_ack,
  input  logic [INS_W-1:0] imem_data,
  output logic             ins_valid,
  output logic [INS_W-1:0] ins,
  output logic [PC_W-1:0]  ins_pc,
  input  logic             ins_ready,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic [CW-1:0]    count
);
  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic              req_q, req_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              push, pop, fifo_empty, fifo_full;
  logic [CW-1:0]     cnt_next;
  logic [PC_W-1:0]   pc_inc;
  logic [INS_W+PC_W-1:0] rdata;

  assign push     = (state_q == REQ) & imem_ack & ~redirect;
  assign pop      = ins_ready & ~fifo_empty;
  assign cnt_next = count + CW'(push) - CW'(pop & ~redirect);
  assign pc_inc   = fetch_pc_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    if (redirect) fetch_pc_d = redirect_pc;
    unique case (state_q)
      IDLE: begin
        if (!redirect && !fifo_full) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = fetch_pc_q[AW-1:0];
        end
      end
      REQ: begin
        if (redirect) begin
          // Without an ack the request cannot be withdrawn, so ride it out in DROP.
          if (imem_ack) begin
            state_d = IDLE;
            req_d   = 1'b0;
          end else begin
            state_d = DROP;
          end
        end else if (imem_ack) begin
          fetch_pc_d = pc_inc;
          if (cnt_next < CW'(DEPTH)) begin
            addr_d = pc_inc[AW-1:0];
          end else begin
            state_d = IDLE;
            req_d   = 1'b0;
          end
        end
      end
      DROP: begin
        if (imem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state_q    <= IDLE;
      fetch_pc_q <= PC_W'(RESET_PC);
      req_q      <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INS_W + PC_W)
  ) u_fifo (
    .clk   (clk),
    .rstd  (rstd),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({imem_data, fetch_pc_q}),
    .rdata (rdata),
    .count (count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign ins_valid = ~fifo_empty;
  assign ins       = rdata[INS_W+PC_W-1:PC_W];
  assign ins_pc    = rdata[PC_W-1:0];
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed check of fetch_queue against a queue-based
// transaction model of the fetch stage.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk, rstd;
  logic        imem_req, imem_ack, ins_valid, ins_ready, redirect;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data, ins, ins_pc, redirect_pc;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  // Model: buffered {ins, pc} entries, fetch PC, and the outstanding request.
  logic [63:0] mq[$];
  logic [31:0] m_pc;
  logic        m_req, m_drop;
  logic [7:0]  m_addr;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstd(rstd), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .ins_valid(ins_valid),
    .ins(ins), .ins_pc(ins_pc), .ins_ready(ins_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc = 32'h0; m_req = 1'b0; m_drop = 1'b0; m_addr = 8'h0;
  endtask

  // Advance the model over one edge given the inputs presented before it.
  task automatic model_step(input logic ack, input logic rdy, input logic rd,
                            input logic [31:0] rpc, input logic [31:0] data);
    int old_size = mq.size();
    bit acked = m_req && ack;
    if (rd) begin
      mq.delete();
      m_pc = rpc;
      if (acked) begin m_req = 1'b0; m_drop = 1'b0; end
      else if (m_req) m_drop = 1'b1;
    end else begin
      if (rdy && old_size > 0) void'(mq.pop_front());
      if (acked) begin
        if (m_drop) begin
          m_req = 1'b0; m_drop = 1'b0;
        end else begin
          mq.push_back({data, m_pc});
          m_pc = m_pc + 32'd1;
          if (mq.size() < DEPTH) m_addr = m_pc[7:0];
          else m_req = 1'b0;
        end
      end else if (!m_req && old_size < DEPTH) begin
        m_req = 1'b1;
        m_addr = m_pc[7:0];
      end
    end
  endtask

  task automatic compare_all();
    logic [63:0] head;
    head = (mq.size() > 0) ? mq[0] : 64'h0;
    check("imem_req", imem_req, m_req);
    check("imem_addr", imem_addr, m_addr);
    check("count", count, mq.size());
    check("ins_valid", ins_valid, mq.size() > 0);
    check("ins", ins, head[63:32]);
    check("ins_pc", ins_pc, head[31:0]);
  endtask

  // Called at a negedge: drive inputs, step the model, then check at next negedge.
  task automatic cyc(input logic ack, input logic rdy, input logic rd, input logic [31:0] rpc);
    logic [31:0] data;
    data = $urandom;
    imem_ack = ack; ins_ready = rdy; redirect = rd; redirect_pc = rpc; imem_data = data;
    model_step(ack, rdy, rd, rpc, data);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rstd = 1'b0; imem_ack = 1'b0; ins_ready = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; imem_data = 32'h0;
    model_reset();
    #1;
    check("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, 8'h0);
    check("rst_valid", ins_valid, 1'b0);
    check("rst_count", count, 3'd0);
    check("rst_ins", ins, 32'h0);
    check("rst_ins_pc", ins_pc, 32'h0);
    @(negedge clk);
    rstd = 1'b1;

    // zero-wait memory, execute always ready
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("stream_count_max1", count <= 3'd1, 1'b1);

    // execute stalled: queue fills, request stops
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("full_count", count, 3'd4);
    check("full_req", imem_req, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0);

    // slow memory with redirect while waiting -> DROP path
    cyc(1'b0, 1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 32'h40);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("drop_holds_req", imem_req, 1'b1);
    for (int i = 0; i < 8; i++) cyc(i % 3 == 2, 1'b1, 1'b0, 32'h0);

    // redirect coinciding with an ack
    cyc(1'b1, 1'b1, 1'b1, 32'h10);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);

    // PC wrap
    cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - $urandom_range(0, 3)) : $urandom;
      cyc($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 55,
          $urandom_range(0, 99) < 5, rpc);
    end

    // async reset with two buffered and one outstanding
    redirect = 1'b0;
    cyc(1'b1, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("pre_rst_count", count, 3'd2);
    check("pre_rst_req", imem_req, 1'b1);
    imem_ack = 1'b0;
    #2 rstd = 1'b0;
    #1;
    check("arst_req", imem_req, 1'b0);
    check("arst_valid", ins_valid, 1'b0);
    check("arst_count", count, 3'd0);
    model_reset();
    @(negedge clk);
    rstd = 1'b1;
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
